// File: rtl/bitcnt_iter.sv
// bitcnt_iter: iterative cpop / clz / ctz unit, CHUNK bits examined per cycle,
// valid/ready on issue and result sides, synchronous flush.
// Optional macro BITCNT_WORD_EN (WIDTH=64 only): wop=1 restricts the operation
// to a[31:0]. Without it, wop is accepted but ignored.
module bitcnt_iter #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [1:0]             op,
  input  logic                   wop,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(WIDTH):0] result
);

  localparam int RW = $clog2(WIDTH) + 1;
  localparam int K  = WIDTH / CHUNK;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] OP_CPOP = 2'b00;
  localparam logic [1:0] OP_CLZ  = 2'b01;
  localparam logic [1:0] OP_CTZ  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            out_valid_q, out_valid_d;
  logic [RW-1:0]   result_q, result_d;

  logic [CHUNK-1:0] chunk;
  logic [RW-1:0]    chunk_pop;
  logic [RW-1:0]    chunk_lz;
  logic             chunk_seen;
  logic [WIDTH-1:0] a_rev;
  logic [WIDTH-1:0] load_val;
  logic             last_chunk;

`ifdef BITCNT_WORD_EN
  logic wop_q, wop_d;
`else
  logic unused_wop;
  assign unused_wop = wop;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

  // Population count and leading-zero count of the chunk currently at the top.
  always_comb begin
    chunk      = operand_q[WIDTH-1 -: CHUNK];
    chunk_pop  = '0;
    chunk_lz   = '0;
    chunk_seen = 1'b0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      chunk_pop = chunk_pop + RW'(chunk[i]);
      if (!chunk_seen && !chunk[CHUNK-1-i]) chunk_lz = chunk_lz + RW'(1);
      else chunk_seen = 1'b1;
    end
  end

  // Operand as loaded on accept: bit-reversed for ctz so both zero counts scan from the top.
  always_comb begin
    a_rev = '0;
    for (int unsigned i = 0; i < WIDTH; i++) a_rev[i] = a[WIDTH-1-i];
    load_val = (op == OP_CTZ) ? a_rev : a;
`ifdef BITCNT_WORD_EN
    if (wop) begin
      case (op)
        OP_CLZ:  load_val = {a[31:0], {(WIDTH-32){1'b1}}};
        OP_CTZ:  load_val = {a_rev[WIDTH-1 -: 32], {(WIDTH-32){1'b1}}};
        default: load_val = {a[31:0], {(WIDTH-32){1'b0}}};
      endcase
    end
`endif
  end

  // End of scan: last chunk of the operand (or of the upper word for word cpop).
  always_comb begin
    last_chunk = (idx_q == IW'(K-1));
`ifdef BITCNT_WORD_EN
    if (wop_q && (op_q == OP_CPOP || op_q == OP_RSVD) && (idx_q == IW'(K/2-1)))
      last_chunk = 1'b1;
`endif
  end

  // Next-state and datapath control. The result register and out_valid are loaded
  // one cycle after entering DONE so both leave the unit from flops.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    operand_d   = operand_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
`ifdef BITCNT_WORD_EN
    wop_d       = wop_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d      = op;
          operand_d = load_val;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = S_RUN;
`ifdef BITCNT_WORD_EN
          wop_d     = wop;
`endif
        end
      end
      S_RUN: begin
        operand_d = operand_q << CHUNK;
        idx_d     = idx_q + IW'(1);
        if (op_q == OP_CLZ || op_q == OP_CTZ) begin
          if (chunk == '0) begin
            acc_d = acc_q + RW'(CHUNK);
          end else begin
            acc_d   = acc_q + chunk_lz;
            state_d = S_DONE;
          end
        end else begin
          acc_d = acc_q + chunk_pop;
        end
        if (last_chunk) state_d = S_DONE;
      end
      S_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          result_d    = (op_q == OP_RSVD) ? '0 : acc_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      operand_q   <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
`ifdef BITCNT_WORD_EN
      wop_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      operand_q   <= operand_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
`ifdef BITCNT_WORD_EN
      wop_q       <= wop_d;
`endif
    end
  end

endmodule
